sar_result_serializer: RTL
==========================

Name: sar_result_serializer

Overview:
- Downstream stage of the 10-bit CS SAR logic.
- Captures each finished conversion word (sar[9:0] qualified by eoc) into a small FIFO and ships it off-chip as framed serial data: sdo, sclk, frame sync fs.
- Decouples conversion rate from readout rate and flags dropped samples.
- Each frame carries a rolling conversion tag so the receiver can detect gaps.

Parameters:
- DATA_W, 10, conversion word width; equals the SAR resolution.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- CLK_DIV, 2, clk cycles per sclk half-period; ≥1.
- TAG_W, 2, width of the rolling conversion tag prepended to each frame.

Ports:
- clk  in  1  system clock; same clock as the SAR logic.
- rst  in  1  reset, synchronous, active-high.
- eoc  in  1  end-of-conversion from the SAR logic; sar is valid while eoc is high.
- sar  in  DATA_W  conversion result.
- ser_en  in  1  enables starting new frames.
- ovf_clr  in  1  clears the sticky overflow flag.
- sdo  out  1  serial data, MSB first.
- sclk  out  1  serial clock; idles low.
- fs  out  1  frame sync; high for the whole frame.
- busy  out  1  high when the serializer is not IDLE.
- overflow  out  1  sticky; a sample was dropped.
- level  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset values: sdo=0, sclk=0, fs=0, busy=0, overflow=0, level=0. Reset also sets FIFO pointers to 0, tag to 0, state to IDLE, eoc_q to 0.
- Reset mid-frame: all outputs return to reset values at the next edge; buffered data is discarded.
- Capture:
  - cap = eoc & ~eoc_q, where eoc_q is eoc registered. eoc held high for several cycles therefore yields exactly one capture.
  - On cap, the entry {tag, sar} is written at that edge, and tag increments mod 2^TAG_W.
  - The tag increments on every cap, including dropped ones.
- Overflow:
  - If the FIFO is full and no pop occurs in the same cycle, the sample is dropped and overflow is set.
  - Capture and pop in the same cycle while full: the write is accepted, level is unchanged, no overflow.
  - Capture and pop in the same cycle while empty cannot occur, because a pop requires the FIFO to be non-empty at the prior edge.
  - ovf_clr clears overflow; if overflow is set and ovf_clr is asserted in the same cycle, set wins.
- level updates at the same edge as the write or pop and never exceeds DEPTH.
- Frame format: FW = TAG_W + DATA_W bits (12 by default), ordered tag MSB..LSB, then data MSB..LSB.
- Bit timing:
  - Bit period = 2*CLK_DIV clk cycles.
  - sdo changes only with sclk falling, or at frame start; the receiver samples on sclk rising.
- State machine, states IDLE, SHIFT, GAP:
  - IDLE: if ser_en=1 and level>0, at the next edge: pop the FIFO, load the shift register, fs←1, sdo←frame MSB, sclk stays 0, clear div_cnt and bit_cnt, go to SHIFT. Otherwise stay in IDLE with sdo=0.
  - SHIFT:
    - div_cnt counts 0..CLK_DIV-1; at terminal count, sclk toggles and div_cnt wraps.
    - On each 1→0 toggle, bit_cnt increments and sdo takes the next bit.
    - On the falling toggle that ends bit FW-1: fs←0, sdo←0, go to GAP.
    - fs is high for exactly FW*2*CLK_DIV cycles.
  - GAP: sclk=0, fs=0, sdo=0 for 2*CLK_DIV cycles, then IDLE.
  - Minimum frame-to-frame spacing: (FW+1)*2*CLK_DIV + 1 cycles (53 at defaults).
- ser_en deasserted mid-frame: the current frame completes; no new frame starts.
- Captures continue during SHIFT and GAP.
- busy = (state != IDLE).
- Latency: cap at edge T with the FIFO empty and ser_en=1 gives fs high at edge T+1, and the first sclk rise CLK_DIV cycles after that.
- Width rules: FIFO pointers are $clog2(DEPTH) bits and wrap naturally; the tag wraps 2^TAG_W-1 → 0.

Decomposition:
- Shared package sar_pkg:
  - SAR_BITS=10, SER_TAG_W=2.
  - Serializer state enum (IDLE, SHIFT, GAP).
  - Function frame_w(TAG_W, DATA_W).
- One sub-module: sar_result_fifo, a synchronous FIFO with wr_en/rd_en/full/empty/level and the full-with-simultaneous-pop write rule.
- Top level holds capture edge-detect, tag counter, overflow flag and the shift FSM.

Test Plan:
- Single conversion: eoc pulse with sar=10'h2A5, FIFO empty, ser_en=1 → fs high 48 cycles, 12 bits sampled on sclk rise = 2'b00,10'b1010100101; sclk period 4 cycles; busy falls 52 cycles after fs rise.
- eoc held high 5 cycles with sar=10'h3FF → exactly one frame; tag=0; level peaks at 1.
- Overflow: ser_en=0, 5 eoc pulses with sar=1..5 → level=4, overflow=1. Then ser_en=1 → frames carry tags 0,1,2,3 with data 1,2,3,4; the 5th sample is absent. ovf_clr → overflow=0.
- Full plus simultaneous pop: FIFO full, eoc edge on the same cycle as an IDLE pop → level stays 4, overflow stays 0, the new sample appears as the last frame.
- ser_en dropped at bit 5 of a frame with 2 entries queued → the frame completes with all 12 bits; no further fs while ser_en=0; level=1.
- rst asserted mid-SHIFT → next cycle sdo=sclk=fs=busy=0, level=0. Next eoc with sar=10'h001 → frame tag 0.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared definitions for the SAR conversion back end: resolution, tag width,
// serializer state encoding and the frame-width helper.
package sar_pkg;

    localparam int SAR_BITS  = 10;
    localparam int SER_TAG_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_e;

    // Bits per serial frame: rolling tag followed by the conversion word.
    function automatic int frame_w(input int tag_w, input int data_w);
        return tag_w + data_w;
    endfunction

endpackage

// File: rtl/sar_result_serializer_if.sv
// Bundles the conversion input, control and serial output signals of the
// result serializer. master = the environment, slave = the serializer.
interface sar_ser_if #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 4
) ();

    logic                       eoc;
    logic [DATA_W-1:0]          sar;
    logic                       ser_en;
    logic                       ovf_clr;
    logic                       sdo;
    logic                       sclk;
    logic                       fs;
    logic                       busy;
    logic                       overflow;
    logic [$clog2(DEPTH+1)-1:0] level;

    modport master (
        output eoc, sar, ser_en, ovf_clr,
        input  sdo, sclk, fs, busy, overflow, level
    );

    modport slave (
        input  eoc, sar, ser_en, ovf_clr,
        output sdo, sclk, fs, busy, overflow, level
    );

endinterface

// File: rtl/sar_result_fifo.sv
// Small synchronous FIFO holding tagged conversion words. A write into a full
// FIFO is accepted only when a pop happens in the same cycle.
module sar_result_fifo
    import sar_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign rd_ok   = rd_en & ~empty;
    assign wr_ok   = wr_en & (~full | rd_ok);
    assign rd_data = mem[rd_ptr];

    // Storage write port.
    // NOTE: the array has no reset; pointers and level are reset, so stale words can never be read.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(wr_ok) - LVL_W'(rd_ok);
        end
    end

endmodule

// File: rtl/sar_result_serializer.sv
// Captures finished SAR conversions into a FIFO and ships them as framed
// serial data (tag then data, MSB first) with sclk and frame sync.
module sar_result_serializer
    import sar_pkg::*;
#(
    parameter int DATA_W  = SAR_BITS,
    parameter int DEPTH   = 4,
    parameter int CLK_DIV = 2,
    parameter int TAG_W   = SER_TAG_W
) (
    input  logic      clk,
    input  logic      rst,
    sar_ser_if.slave  bus
);

    localparam int FW    = frame_w(TAG_W, DATA_W);
    localparam int DIV_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam int BIT_W = $clog2(FW);

    ser_state_e       state;
    logic             eoc_q;
    logic [TAG_W-1:0] tag;
    logic             overflow;
    logic [FW-1:0]    sreg;
    logic             sdo;
    logic             sclk;
    logic             fs;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;

    logic             cap;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FW-1:0]    fifo_out;

    assign cap  = bus.eoc & ~eoc_q;
    assign pop  = (state == IDLE) & bus.ser_en & ~fifo_empty;
    assign drop = cap & fifo_full & ~pop;

    sar_result_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cap),
        .wr_data ({tag, bus.sar}),
        .rd_en   (pop),
        .rd_data (fifo_out),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (bus.level)
    );

    // eoc edge detect and rolling tag; the tag advances even for dropped samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            eoc_q <= 1'b0;
            tag   <= '0;
        end else begin
            eoc_q <= bus.eoc;
            if (cap) tag <= tag + TAG_W'(1);
        end
    end

    // Sticky overflow; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (bus.ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // Frame FSM: load on pop, shift on sclk falling toggles, then a one-bit-period gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sreg    <= '0;
            sdo     <= 1'b0;
            sclk    <= 1'b0;
            fs      <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sclk <= 1'b0;
                    fs   <= 1'b0;
                    sdo  <= 1'b0;
                    if (pop) begin
                        sreg    <= fifo_out << 1;
                        sdo     <= fifo_out[FW-1];
                        fs      <= 1'b1;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        if (sclk) begin
                            if (bit_cnt == BIT_W'(FW - 1)) begin
                                fs    <= 1'b0;
                                sdo   <= 1'b0;
                                state <= GAP;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                                sdo     <= sreg[FW-1];
                                sreg    <= sreg << 1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                GAP: begin
                    if (div_cnt == DIV_W'(2 * CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sdo      = sdo;
    assign bus.sclk     = sclk;
    assign bus.fs       = fs;
    assign bus.busy     = (state != IDLE);
    assign bus.overflow = overflow;

endmodule
